imm_encoder: RTL and testbench



---
 rtl/imm_encoder_pkg.sv | 40 ++++
 rtl/imm_encoder_pack.sv | 54 +++++
 rtl/imm_encoder.sv | 97 +++++++++
 tb/tb_imm_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RISC-V immediate encoder: format codes, per-format
// immediate field masks and the default error-counter width.
package imm_encoder_pkg;

    // Codes match the selector of the core's immediate sign-extension stage.
    typedef enum logic [2:0] {
        FMT_I     = 3'b000,
        FMT_S     = 3'b001,
        FMT_B     = 3'b010,
        FMT_U     = 3'b011,
        FMT_J     = 3'b100,
        FMT_SHAMT = 3'b101
    } imm_fmt_e;

    localparam int ERR_CNT_W_DEF = 16;

    localparam logic [31:0] MASK_I     = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S     = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B     = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U     = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J     = 32'hFFFF_F000;
    localparam logic [31:0] MASK_SHAMT = 32'h01F0_0000;

    // Invalid codes select an empty mask so the base word passes through untouched.
    function automatic logic [31:0] fmt_mask(input logic [2:0] fmt);
        logic [31:0] mask;
        mask = '0;
        case (imm_fmt_e'(fmt))
            FMT_I:     mask = MASK_I;
            FMT_S:     mask = MASK_S;
            FMT_B:     mask = MASK_B;
            FMT_U:     mask = MASK_U;
            FMT_J:     mask = MASK_J;
            FMT_SHAMT: mask = MASK_SHAMT;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational mask/pack/range-check of one immediate into a base instruction.
// Range checking is present only when IMM_ENCODER_CHECK_EN is defined.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [31:0] w_mask;
    logic [31:0] w_field;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_mask  = fmt_mask(i_fmt);
        w_field = '0;
        case (imm_fmt_e'(i_fmt))
            FMT_I:     w_field = {i_imm[11:0], 20'b0};
            FMT_S:     w_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
            FMT_B:     w_field = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
            FMT_U:     w_field = {i_imm[31:12], 12'b0};
            FMT_J:     w_field = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
            FMT_SHAMT: w_field = {7'b0, i_imm[4:0], 20'b0};
            default:   w_field = '0;
        endcase
    end

`ifdef IMM_ENCODER_CHECK_EN
    logic w_in_range;

    // "All equal" upper bits means the value fits the field's signed range.
    always_comb begin
        w_in_range = 1'b0;
        case (imm_fmt_e'(i_fmt))
            FMT_I, FMT_S: w_in_range = (i_imm[31:11] == {21{i_imm[31]}});
            FMT_B:        w_in_range = (i_imm[31:12] == {20{i_imm[31]}}) && !i_imm[0];
            FMT_U:        w_in_range = (i_imm[11:0] == 12'b0);
            FMT_J:        w_in_range = (i_imm[31:20] == {12{i_imm[31]}}) && !i_imm[0];
            FMT_SHAMT:    w_in_range = (i_imm[31:5] == 27'b0);
            default:      w_in_range = 1'b0;
        endcase
    end

    assign o_err = !w_in_range;
`else
    assign o_err = 1'b0;
`endif

    assign o_instr = (i_base & ~w_mask) | (o_err ? 32'b0 : w_field);

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipelined RISC-V immediate encoder with saturating error count.
// Build with IMM_ENCODER_CHECK_EN defined to enable range checking and error reporting.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [31:0] w_pack_instr;
    logic        w_pack_err;
    logic        w_a_ready;
    logic        w_b_ready;
    logic        w_accept;

    logic        r_a_valid;
    logic [31:0] r_a_instr;
    logic        r_a_err;
    logic        r_b_valid;
    logic [31:0] r_b_instr;
    logic        r_b_err;

    imm_pack u_pack (
        .i_fmt   (in_fmt),
        .i_imm   (in_imm),
        .i_base  (in_base),
        .o_instr (w_pack_instr),
        .o_err   (w_pack_err)
    );

    // Each stage frees up in the same cycle its occupant leaves, so no bubbles.
    assign w_b_ready = !r_b_valid || out_ready;
    assign w_a_ready = !r_a_valid || w_b_ready;
    assign w_accept  = in_valid && w_a_ready;
    assign in_ready  = w_a_ready;

    // NOTE: sequential state is written with non-blocking assignments only.
    // NOTE: data registers are reset too, so out_instr/out_err read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_instr <= '0;
            r_a_err   <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_instr <= '0;
            r_b_err   <= 1'b0;
        end else begin
            if (w_a_ready) begin
                r_a_valid <= in_valid;
            end
            if (w_accept) begin
                r_a_instr <= w_pack_instr;
                r_a_err   <= w_pack_err;
            end
            if (w_b_ready) begin
                r_b_valid <= r_a_valid;
            end
            if (w_b_ready && r_a_valid) begin
                r_b_instr <= r_a_instr;
                r_b_err   <= r_a_err;
            end
        end
    end

    assign out_valid = r_b_valid;
    assign out_instr = r_b_instr;
    assign out_err   = r_b_err;

`ifdef IMM_ENCODER_CHECK_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_pack_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases, backpressure, random traffic,
// mid-operation reset and error-counter saturation against an arithmetic reference model.
module tb_imm_encoder;

    localparam int TB_ERR_W = 2;
    localparam int ERR_MAX  = (1 << TB_ERR_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_fmt;
    logic [31:0]         in_imm;
    logic [31:0]         in_base;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic                out_err;
    logic [TB_ERR_W-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_err_cnt = 0;
    logic [32:0] exp_q [$];

    imm_encoder #(.ERR_CNT_W(TB_ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IMM_ENCODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Reference model: {err, instr} from signed ranges and shift/mask arithmetic.
    function automatic logic [32:0] ref_encode(input logic [31:0] base, input logic [31:0] imm,
                                               input logic [2:0] fmt);
        int signed   s;
        bit          ok;
        logic [31:0] mask;
        logic [31:0] field;
        s = $signed(imm);
        case (fmt)
            3'd0: begin
                ok = (s >= -2048) && (s <= 2047);
                mask = 32'hFFF00000;
                field = (imm & 32'hFFF) << 20;
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                mask = 32'hFE000F80;
                field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd2: begin
                ok = (s >= -4096) && (s <= 4094) && ((imm % 2) == 0);
                mask = 32'hFE000F80;
                field = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25)
                      | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7);
            end
            3'd3: begin
                ok = (imm % 4096) == 0;
                mask = 32'hFFFFF000;
                field = imm & 32'hFFFFF000;
            end
            3'd4: begin
                ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && ((imm % 2) == 0);
                mask = 32'hFFFFF000;
                field = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
                      | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12);
            end
            3'd5: begin
                ok = imm < 32;
                mask = 32'h01F00000;
                field = (imm & 32'd31) << 20;
            end
            default: begin
                ok = 1'b0;
                mask = 32'h0;
                field = 32'h0;
            end
        endcase
        if (!CHK) ok = 1'b1;
        return {!ok, ok ? ((base & ~mask) | field) : (base & ~mask)};
    endfunction

    logic [31:0] edges [12] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4095,
                                32'hFFFFF000, 32'hFFFFEFFE, 32'd31, 32'd32, 32'h000FFFFE, 32'hFFF00000};

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 10000)) - 32'd5000;
            2:       return edges[$urandom_range(0, 11)];
            default: return $urandom() & 32'hFFFFF000;
        endcase
    endfunction

    // Scoreboard: handshakes sampled on the falling edge, inputs change just after rising.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (int'(err_count) != m_err_cnt) begin
                n_fail++;
                $display("FAIL err_count: got %0d expected %0d", err_count, m_err_cnt);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h with no beat outstanding", out_instr);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({out_err, out_instr} !== e) begin
                        n_fail++;
                        $display("FAIL stream: got err=%b instr=%h expected err=%b instr=%h",
                                 out_err, out_instr, e[32], e[31:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                logic [32:0] r;
                r = ref_encode(in_base, in_imm, in_fmt);
                exp_q.push_back(r);
                if (r[32] && m_err_cnt < ERR_MAX) m_err_cnt++;
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        m_err_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fmt = '0; in_imm = '0; in_base = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_instr, out_err, err_count, in_ready} !== {1'b0, 32'h0, 1'b0, 2'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b instr=%h err=%b cnt=%0d ready=%b expected 0/0/0/0/1",
                     out_valid, out_instr, out_err, err_count, in_ready);
        end
        @(posedge clk); #1;
    endtask

    localparam int ND = 9;
    logic [2:0]  d_fmt  [ND] = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd0};
    logic [31:0] d_base [ND] = '{32'h93, 32'h63, 32'h63, 32'hB7, 32'hEF, 32'h40005013,
                                 32'h12345678, 32'h00112023, 32'h93};
    logic [31:0] d_imm  [ND] = '{32'hFFFFFFFF, 32'd8, 32'd5, 32'h12345000, 32'h800, 32'd7,
                                 32'd0, 32'hFFFFFFFC, 32'd2048};
`ifdef IMM_ENCODER_CHECK_EN
    logic [31:0] d_exp  [ND] = '{32'hFFF00093, 32'h463, 32'h63, 32'h123450B7, 32'h001000EF,
                                 32'h40705013, 32'h12345678, 32'hFE112E23, 32'h93};
    logic        d_err  [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          d_cnt  [ND] = '{0, 0, 1, 1, 1, 1, 2, 2, 3};
`else
    logic [31:0] d_exp  [ND] = '{32'hFFF00093, 32'h463, 32'h263, 32'h123450B7, 32'h001000EF,
                                 32'h40705013, 32'h12345678, 32'hFE112E23, 32'h80000093};
    logic        d_err  [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          d_cnt  [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    task automatic test_directed();
        out_ready = 1'b1;
        for (int i = 0; i < ND; i++) begin
            in_valid = 1'b1; in_fmt = d_fmt[i]; in_base = d_base[i]; in_imm = d_imm[i];
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_ready[%0d]: got %b expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_early[%0d]: out_valid got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_instr, out_err} !== {1'b1, d_exp[i], d_err[i]}
                || int'(err_count) != d_cnt[i]) begin
                n_fail++;
                $display("FAIL directed[%0d]: got v=%b instr=%h err=%b cnt=%0d expected v=1 instr=%h err=%b cnt=%0d",
                         i, out_valid, out_instr, out_err, err_count, d_exp[i], d_err[i], d_cnt[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] b_base [3];
        logic [31:0] b_imm  [3];
        logic [2:0]  b_fmt  [3];
        logic [32:0] exp0;
        for (int i = 0; i < 3; i++) begin
            b_base[i] = $urandom(); b_imm[i] = rand_imm(); b_fmt[i] = 3'($urandom_range(0, 5));
        end
        exp0 = ref_encode(b_base[0], b_imm[0], b_fmt[0]);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_base = b_base[i]; in_imm = b_imm[i]; in_fmt = b_fmt[i];
            @(negedge clk);
            n_cmp++;
            if (in_ready !== (i < 2)) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b expected %b", i, in_ready, i < 2);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready, out_valid, out_err, out_instr} !== {1'b0, 1'b1, exp0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ready=%b v=%b err=%b instr=%h expected 0/1/%b/%h",
                         k, in_ready, out_valid, out_err, out_instr, exp0[32], exp0[31:0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d beats outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_fmt    = 3'($urandom_range(0, 7));
            in_base   = $urandom();
            in_imm    = rand_imm();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d beats outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_fmt = 3'd6; in_base = $urandom(); in_imm = $urandom();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_instr, err_count} !== {1'b0, 1'b1, 32'h0, 2'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b ready=%b instr=%h cnt=%0d expected 0/1/0/0",
                     out_valid, in_ready, out_instr, err_count);
        end
        exp_q.delete();
        m_err_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stale[%0d]: out_valid got %b expected 0", k, out_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_fmt = 3'd6 | 3'($urandom_range(0, 1));
            in_base = $urandom(); in_imm = $urandom();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_cmp++;
        if (int'(err_count) != (CHK ? ERR_MAX : 0) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL saturation: got cnt=%0d pending=%0d expected cnt=%0d pending=0",
                     err_count, exp_q.size(), CHK ? ERR_MAX : 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
